mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive fetch losses after which fetch wins arbitration.
REQ-002 SHALL have parameter IO_BASE, default 32'h0003_0000; addresses >= IO_BASE are IO.
REQ-003 clk_in  input  1  system clock; one clock; all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 rob_clear  input  1  pipeline flush.
REQ-007 mem_din  input  8  RAM read data, valid the cycle after mem_a is driven.
REQ-008 mem_dout  output  8  RAM write byte.
REQ-009 mem_a  output  32  RAM byte address.
REQ-010 mem_wr  output  1  1 = write this cycle.
REQ-011 io_buffer_full  input  1  UART buffer full.
REQ-012 if_req / if_addr  input  1 / 32  instruction-word read request and address.
REQ-013 if_grant / if_valid / if_data  output  1 / 1 / 32  accept pulse, data-valid pulse, fetched word.
REQ-014 ls_req / ls_we / ls_addr / ls_wdata / ls_type  input  1 / 1 / 32 / 32 / 3  load-store request; ls_type[2] signed, ls_type[1:0] 00 byte, 01 half, 10 or 11 word.
REQ-015 ls_grant / ls_valid / ls_rdata  output  1 / 1 / 32  accept pulse, done pulse (load data or store ack), load result.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, RESP.
REQ-018 Grant SHALL be combinational, only in IDLE with rdy_in=1 and rob_clear=0; at most one grant per cycle; requester must hold req until grant.
REQ-019 Arbitration SHALL favour ls; fetch wins when starve counter == STARVE_LIMIT or ls_req=0.
REQ-020 Starve counter SHALL increment (saturating at STARVE_LIMIT) on each cycle fetch is requesting but ls is granted, and clear on any if_grant.
REQ-021 On grant at cycle t, address, data, type, requester SHALL be latched; N = 1/2/4 bytes (fetch always 4).
REQ-022 READ: byte i SHALL be addressed (mem_a = base+i, mem_wr=0) in cycle t+1+i and captured from mem_din at the end of cycle t+2+i into bits [8i+7:8i], little-endian.
REQ-023 READ: after the last capture, state RESP for one cycle; valid pulse and data SHALL appear in cycle t+N+2; then IDLE, new grant allowed in that same cycle.
REQ-024 Load result SHALL be zero- or sign-extended from bit 8N-1 per ls_type[2].
REQ-025 WRITE: byte i SHALL be driven (mem_a = base+i, mem_dout = wdata[8i+7:8i], mem_wr=1) in cycle t+1+i; ls_valid pulse in cycle t+N+1; ls_rdata = 0.
REQ-026 WRITE to IO address with io_buffer_full=1 SHALL drive mem_wr=0 and hold the byte index until io_buffer_full=0.
REQ-027 rob_clear=1 during READ or RESP of either requester SHALL return to IDLE next edge with no valid pulse.
REQ-028 rob_clear SHALL NOT abort WRITE; the store completes and ls_valid pulses normally.
REQ-029 rdy_in=0 SHALL hold state, counters, latches; mem_wr forced 0; no grants or valid pulses.
REQ-030 In IDLE and RESP, mem_a, mem_dout, mem_wr SHALL be 0.
REQ-031 if_valid and ls_valid SHALL each be single-cycle pulses, never simultaneous.

Reset
REQ-032 rst_in=1 SHALL asynchronously force IDLE, starve counter 0, byte index 0, all outputs 0, data registers 0.
REQ-033 Reset mid-operation SHALL abandon the transfer without any valid pulse; first grant possible the cycle after rst_in deasserts.

Verification
REQ-034 Fetch 0x1000, RAM bytes 13,00,00,00 -> if_grant cycle t, mem_a 0x1000..0x1003 cycles t+1..t+4, if_valid with 0x00000013 at t+6.
REQ-035 Signed byte load 0x20 holding 0x80 -> ls_rdata 0xFFFFFF80 at t+3; unsigned -> 0x00000080.
REQ-036 Word store 0xDEADBEEF to 0x40 with rob_clear pulsed at t+2 -> bytes EF,BE,AD,DE written t+1..t+4, ls_valid at t+5.
REQ-037 Byte store 0x41 to 0x30000, io_buffer_full high 3 cycles -> mem_wr 0 for 3 cycles, then one write, ls_valid next cycle.
REQ-038 ls_req and if_req held continuously -> fetch granted after exactly 4 consecutive ls grants, counter then 0.
REQ-039 rob_clear in cycle t+3 of a fetch -> IDLE next cycle, no if_valid; rst_in mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// load/store, serialising each access into 1, 2 or 4 single-byte cycles.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_type,
  output logic        ls_grant,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] starve_reg, starve_next;
  logic [2:0]       idx_reg, idx_next;
  logic [31:0]      base_reg;
  logic [31:0]      wdata_reg;
  logic [2:0]       type_reg;
  logic             is_ls_reg;
  logic             we_reg;

  logic        grant_ok;
  logic        fetch_wins;
  logic        take_grant;
  logic        in_resp;
  logic        io_stall;
  logic [2:0]  nbytes;
  logic [31:0] cur_addr;
  logic [31:0] prev_addr;
  logic [7:0]  wr_byte;
  logic [31:0] data_word;
  logic [31:0] load_ext;

  // Arbitration: loads/stores win unless fetch has lost STARVE_LIMIT times in a row.
  assign grant_ok   = (state_reg == ST_IDLE) && rdy_in && !rob_clear && !rst_in;
  assign fetch_wins = if_req && (!ls_req || (starve_reg == STARVE_MAX));
  assign if_grant   = grant_ok && fetch_wins;
  assign ls_grant   = grant_ok && ls_req && !fetch_wins;
  assign take_grant = if_grant || ls_grant;

  always_comb begin
    case (type_reg[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign cur_addr  = base_reg + {29'd0, idx_reg};
  assign prev_addr = cur_addr - 32'd1;
  assign io_stall  = (cur_addr >= IO_BASE) && io_buffer_full;
  assign wr_byte   = wdata_reg[{idx_reg[1:0], 3'b000} +: 8];

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    idx_next    = idx_reg;
    if (rdy_in) begin
      case (state_reg)
        ST_IDLE: begin
          if (if_grant) begin
            state_next  = ST_READ;
            idx_next    = 3'd0;
            starve_next = '0;
          end else if (ls_grant) begin
            state_next = ls_we ? ST_WRITE : ST_READ;
            idx_next   = 3'd0;
            if (if_req && (starve_reg != STARVE_MAX))
              starve_next = starve_reg + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (rob_clear) begin
            state_next = ST_IDLE;
            idx_next   = 3'd0;
          end else if (idx_reg == nbytes) begin
            state_next = ST_RESP;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (idx_reg == nbytes - 3'd1) begin
              state_next = ST_RESP;
              idx_next   = 3'd0;
            end else begin
              idx_next = idx_reg + 3'd1;
            end
          end
        end
        ST_RESP: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_reg)
      ST_READ: begin
        // While frozen, re-present the byte still awaiting capture so mem_din stays valid.
        if (!rdy_in)
          mem_a = (idx_reg == 3'd0) ? base_reg : prev_addr;
        else if (idx_reg != nbytes)
          mem_a = cur_addr;
      end
      ST_WRITE: begin
        mem_a    = cur_addr;
        mem_dout = wr_byte;
        mem_wr   = rdy_in && !io_stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= ST_IDLE;
      starve_reg <= '0;
      idx_reg    <= '0;
      base_reg   <= '0;
      wdata_reg  <= '0;
      type_reg   <= '0;
      is_ls_reg  <= 1'b0;
      we_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      idx_reg    <= idx_next;
      if (take_grant) begin
        base_reg  <= if_grant ? if_addr : ls_addr;
        wdata_reg <= if_grant ? 32'd0 : ls_wdata;
        type_reg  <= if_grant ? 3'b010 : ls_type;
        is_ls_reg <= ls_grant;
        we_reg    <= ls_grant && ls_we;
      end
    end
  end

  // Byte lane gi captures mem_din one cycle after byte gi was addressed.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
          lane_reg <= '0;
        else if (rdy_in && (state_reg == ST_READ) && (idx_reg == 3'(gi + 1)))
          lane_reg <= mem_din;
      end
      assign data_word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  always_comb begin
    case (type_reg[1:0])
      2'b00:   load_ext = {{24{type_reg[2] & data_word[7]}}, data_word[7:0]};
      2'b01:   load_ext = {{16{type_reg[2] & data_word[15]}}, data_word[15:0]};
      default: load_ext = data_word;
    endcase
  end

  // A flush cancels a pending read response, but a store always acknowledges.
  assign in_resp  = (state_reg == ST_RESP);
  assign busy     = (state_reg != ST_IDLE);
  assign if_valid = in_resp && !is_ls_reg && rdy_in && !rob_clear;
  assign ls_valid = in_resp && is_ls_reg && rdy_in && (we_reg || !rob_clear);
  assign if_data  = (in_resp && !is_ls_reg) ? data_word : '0;
  assign ls_rdata = (in_resp && is_ls_reg && !we_reg) ? load_ext : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// byte-array RAM and a behavioural load model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        if_req, if_grant, if_valid;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_grant, ls_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_type;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ram [0:65535];

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_type(ls_type),
    .ls_grant(ls_grant), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // RAM: data for the address presented in one cycle appears on mem_din in the next.
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] typ);
    int n;
    longint unsigned v;
    n = (typ[1:0] == 2'b00) ? 1 : (typ[1:0] == 2'b01) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ram[16'(addr + 32'(i))]) << (8 * i);
    if (typ[2] && (v >= (64'd1 << (8 * n - 1))))
      v -= (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; rob_clear = 1'b0;
    io_buffer_full = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h1000; ls_addr = 32'h20;
    tick(); settle();
    n_tests++;
    if ({busy, mem_wr, if_grant, ls_grant, if_valid, ls_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {busy, mem_wr, if_grant, ls_grant, if_valid, ls_valid});
    end
    n_tests++;
    if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin
      n_fail++; $display("FAIL reset_mem: mem_a=%h mem_dout=%h want 0", mem_a, mem_dout);
    end
    n_tests++;
    if (if_data !== 32'd0 || ls_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: if_data=%h ls_rdata=%h want 0", if_data, ls_rdata);
    end
    rst_in = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h00; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    tick(); if_req = 1'b1; if_addr = 32'h1000; settle();
    n_tests++;
    if (if_grant !== 1'b1 || ls_grant !== 1'b0) begin
      n_fail++; $display("FAIL fetch_grant: if_grant=%b ls_grant=%b want 1/0", if_grant, ls_grant);
    end
    for (int k = 1; k <= 6; k++) begin
      tick(); if_req = 1'b0; settle();
      if (k <= 4) begin
        n_tests++;
        if (mem_a !== 32'h1000 + 32'(k - 1) || mem_wr !== 1'b0) begin
          n_fail++; $display("FAIL fetch_addr t+%0d: mem_a=%h mem_wr=%b want %h/0", k, mem_a, mem_wr, 32'h1000 + 32'(k - 1));
        end
      end
      n_tests++;
      if (k < 6 && if_valid !== 1'b0) begin
        n_fail++; $display("FAIL fetch_early_valid t+%0d: if_valid=%b want 0", k, if_valid);
      end else if (k == 6 && (if_valid !== 1'b1 || if_data !== 32'h0000_0013)) begin
        n_fail++; $display("FAIL fetch_data t+6: if_valid=%b if_data=%h want 1/00000013", if_valid, if_data);
      end
    end
    tick(); settle();
    n_tests++;
    if (if_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fetch_end: if_valid=%b busy=%b want 0/0", if_valid, busy);
    end
  endtask

  task automatic test_load_sign();
    logic [31:0] exp_v [2];
    logic [2:0]  typ_v [2];
    do_reset();
    ram[16'h0020] = 8'h80;
    typ_v[0] = 3'b100; exp_v[0] = 32'hFFFF_FF80;
    typ_v[1] = 3'b000; exp_v[1] = 32'h0000_0080;
    for (int j = 0; j < 2; j++) begin
      tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_type = typ_v[j]; settle();
      n_tests++;
      if (ls_grant !== 1'b1) begin
        n_fail++; $display("FAIL load_grant[%0d]: ls_grant=%b want 1", j, ls_grant);
      end
      for (int k = 1; k <= 3; k++) begin
        tick(); ls_req = 1'b0; settle();
        n_tests++;
        if (k < 3 && ls_valid !== 1'b0) begin
          n_fail++; $display("FAIL load_early_valid[%0d] t+%0d: ls_valid=%b want 0", j, k, ls_valid);
        end else if (k == 3 && (ls_valid !== 1'b1 || ls_rdata !== exp_v[j] || if_valid !== 1'b0)) begin
          n_fail++; $display("FAIL load_sign[%0d] t+3: ls_valid=%b ls_rdata=%h want 1/%h", j, ls_valid, ls_rdata, exp_v[j]);
        end
      end
    end
  endtask

  task automatic test_random_loads();
    do_reset();
    for (int it = 0; it < 24; it++) begin
      logic [31:0] addr, expd, got;
      logic [2:0]  typ;
      bit          use_if, seen, addr_bad;
      int          n, lat;
      use_if = 1'($urandom_range(0, 1));
      addr   = 32'h100 + 32'($urandom_range(0, 255));
      typ    = use_if ? 3'b010 : 3'($urandom_range(0, 7));
      n      = (typ[1:0] == 2'b00) ? 1 : (typ[1:0] == 2'b01) ? 2 : 4;
      expd   = model_load(addr, typ);
      tick();
      if (use_if) begin if_req = 1'b1; if_addr = addr; end
      else begin ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr; ls_type = typ; end
      settle();
      n_tests++;
      if (if_grant !== use_if || ls_grant !== !use_if) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: if_grant=%b ls_grant=%b want %b/%b", it, if_grant, ls_grant, use_if, !use_if);
      end
      seen = 1'b0; lat = 0; got = '0; addr_bad = 1'b0;
      for (int k = 1; k <= n + 4 && !seen; k++) begin
        tick(); if_req = 1'b0; ls_req = 1'b0; settle();
        if (k <= n && (mem_a !== addr + 32'(k - 1) || mem_wr !== 1'b0)) addr_bad = 1'b1;
        if ((use_if ? if_valid : ls_valid) === 1'b1) begin
          seen = 1'b1; lat = k; got = use_if ? if_data : ls_rdata;
          if ((use_if ? ls_valid : if_valid) !== 1'b0) addr_bad = 1'b1;
        end
      end
      n_tests++;
      if (addr_bad) begin
        n_fail++; $display("FAIL rnd_addr[%0d]: byte addressing wrong for base %h n=%0d", it, addr, n);
      end
      n_tests++;
      if (!seen || lat != n + 2 || got !== expd) begin
        n_fail++; $display("FAIL rnd_load[%0d]: addr=%h type=%b valid_at=t+%0d data=%h want t+%0d data=%h", it, addr, typ, lat, got, n + 2, expd);
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] w;
    logic [7:0]  eb;
    w = 32'hDEAD_BEEF;
    do_reset();
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = w; ls_type = 3'b010; settle();
    n_tests++;
    if (ls_grant !== 1'b1) begin
      n_fail++; $display("FAIL store_grant: ls_grant=%b want 1", ls_grant);
    end
    for (int k = 1; k <= 5; k++) begin
      tick(); ls_req = 1'b0; rob_clear = (k == 2); settle();
      if (k <= 4) begin
        eb = w[8 * (k - 1) +: 8];
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h40 + 32'(k - 1) || mem_dout !== eb || ls_valid !== 1'b0) begin
          n_fail++; $display("FAIL store_byte t+%0d: wr=%b a=%h d=%h want 1/%h/%h", k, mem_wr, mem_a, mem_dout, 32'h40 + 32'(k - 1), eb);
        end
      end else begin
        n_tests++;
        if (ls_valid !== 1'b1 || ls_rdata !== 32'd0 || mem_wr !== 1'b0) begin
          n_fail++; $display("FAIL store_ack t+5: ls_valid=%b ls_rdata=%h mem_wr=%b want 1/0/0", ls_valid, ls_rdata, mem_wr);
        end
      end
    end
    tick(); rob_clear = 1'b0; settle();
    n_tests++;
    if ({ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]} !== w || busy !== 1'b0) begin
      n_fail++; $display("FAIL store_ram: ram=%h busy=%b want %h/0", {ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]}, busy, w);
    end
  endtask

  task automatic test_io_stall();
    do_reset();
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_wdata = 32'h5A5A_5A41; ls_type = 3'b000; settle();
    n_tests++;
    if (ls_grant !== 1'b1) begin
      n_fail++; $display("FAIL io_grant: ls_grant=%b want 1", ls_grant);
    end
    for (int k = 1; k <= 5; k++) begin
      tick(); ls_req = 1'b0; io_buffer_full = (k <= 3); settle();
      n_tests++;
      if (k <= 3 && (mem_wr !== 1'b0 || busy !== 1'b1 || ls_valid !== 1'b0)) begin
        n_fail++; $display("FAIL io_stall t+%0d: mem_wr=%b busy=%b ls_valid=%b want 0/1/0", k, mem_wr, busy, ls_valid);
      end else if (k == 4 && (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h41 || ls_valid !== 1'b0)) begin
        n_fail++; $display("FAIL io_write t+4: wr=%b a=%h d=%h want 1/00030000/41", mem_wr, mem_a, mem_dout);
      end else if (k == 5 && (ls_valid !== 1'b1 || mem_wr !== 1'b0)) begin
        n_fail++; $display("FAIL io_ack t+5: ls_valid=%b mem_wr=%b want 1/0", ls_valid, mem_wr);
      end
    end
    // one byte below the IO window is plain RAM and must not stall
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0002_FFFF; ls_wdata = 32'h0000_0077; ls_type = 3'b000;
    io_buffer_full = 1'b1; settle();
    tick(); ls_req = 1'b0; settle();
    n_tests++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h0002_FFFF || mem_dout !== 8'h77) begin
      n_fail++; $display("FAIL io_boundary: wr=%b a=%h d=%h want 1/0002ffff/77", mem_wr, mem_a, mem_dout);
    end
    tick(); io_buffer_full = 1'b0; settle();
    n_tests++;
    if (ls_valid !== 1'b1) begin
      n_fail++; $display("FAIL io_boundary_ack: ls_valid=%b want 1", ls_valid);
    end
  endtask

  task automatic test_starve();
    bit grants[$];
    bit both;
    do_reset();
    ls_addr = 32'h100; ls_we = 1'b0; ls_type = 3'b000; if_addr = 32'h104;
    tick(); if_req = 1'b1; ls_req = 1'b1; settle();
    both = 1'b0;
    for (int c = 0; c < 400 && grants.size() < 10; c++) begin
      if (if_grant === 1'b1 && ls_grant === 1'b1) both = 1'b1;
      if (if_grant === 1'b1) grants.push_back(1'b1);
      else if (ls_grant === 1'b1) grants.push_back(1'b0);
      tick(); settle();
    end
    if_req = 1'b0; ls_req = 1'b0;
    n_tests++;
    if (grants.size() < 10 || both) begin
      n_fail++; $display("FAIL starve_run: grants=%0d both=%b want 10/0", grants.size(), both);
    end
    for (int j = 0; j < grants.size(); j++) begin
      bit exp_f;
      exp_f = (j % 5 == 4);
      n_tests++;
      if (grants[j] !== exp_f) begin
        n_fail++; $display("FAIL starve_seq[%0d]: fetch=%b want %b", j, grants[j], exp_f);
      end
    end
    for (int c = 0; c < 20 && busy === 1'b1; c++) begin
      tick(); settle();
    end
  endtask

  task automatic test_flush();
    bit bad;
    logic [31:0] expd;
    do_reset();
    tick(); if_req = 1'b1; if_addr = 32'h1000; rob_clear = 1'b1; settle();
    n_tests++;
    if (if_grant !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_grant: if_grant=%b want 0", if_grant);
    end
    tick(); rob_clear = 1'b0; settle();
    n_tests++;
    if (if_grant !== 1'b1) begin
      n_fail++; $display("FAIL flush_grant: if_grant=%b want 1", if_grant);
    end
    bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(); if_req = 1'b0; rob_clear = (k == 3); settle();
      if (if_valid !== 1'b0) bad = 1'b1;
      if (k == 4) begin
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL flush_idle t+4: busy=%b want 0", busy);
        end
      end
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL flush_no_valid: if_valid seen=1 want 0");
    end
    // asynchronous reset in the middle of a read
    expd = model_load(32'h100, 3'b010);
    tick(); if_req = 1'b1; if_addr = 32'h100; settle();
    tick(); if_req = 1'b0; settle();
    tick(); settle();
    n_tests++;
    if (busy !== 1'b1 || mem_a !== 32'h101) begin
      n_fail++; $display("FAIL rst_pre: busy=%b mem_a=%h want 1/00000101", busy, mem_a);
    end
    rst_in = 1'b1; #1;
    n_tests++;
    if (busy !== 1'b0 || mem_a !== 32'd0 || mem_wr !== 1'b0 || if_valid !== 1'b0 || if_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_async: busy=%b mem_a=%h mem_wr=%b if_valid=%b want 0/0/0/0", busy, mem_a, mem_wr, if_valid);
    end
    tick(); rst_in = 1'b0; settle();
    tick(); if_req = 1'b1; settle();
    n_tests++;
    if (if_grant !== 1'b1) begin
      n_fail++; $display("FAIL rst_regrant: if_grant=%b want 1", if_grant);
    end
    bad = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(); if_req = 1'b0; settle();
      if (k < 6 && if_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad || if_valid !== 1'b1 || if_data !== expd) begin
      n_fail++; $display("FAIL rst_refetch: stray=%b if_valid=%b if_data=%h want 0/1/%h", bad, if_valid, if_data, expd);
    end
  endtask

  task automatic test_rdy_freeze();
    bit bad;
    logic [31:0] expd;
    do_reset();
    expd = model_load(32'h180, 3'b010);
    tick(); rdy_in = 1'b0; if_req = 1'b1; if_addr = 32'h180; settle();
    n_tests++;
    if (if_grant !== 1'b0) begin
      n_fail++; $display("FAIL rdy_no_grant: if_grant=%b want 0", if_grant);
    end
    tick(); rdy_in = 1'b1; settle();
    n_tests++;
    if (if_grant !== 1'b1) begin
      n_fail++; $display("FAIL rdy_grant: if_grant=%b want 1", if_grant);
    end
    bad = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick(); if_req = 1'b0; rdy_in = !(k >= 2 && k <= 4); settle();
      if (!rdy_in && (busy !== 1'b1 || mem_wr !== 1'b0)) bad = 1'b1;
      if (k < 9 && if_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad || if_valid !== 1'b1 || if_data !== expd) begin
      n_fail++; $display("FAIL rdy_freeze: stray=%b if_valid=%b if_data=%h want 0/1/%h", bad, if_valid, if_data, expd);
    end
    tick(); settle();
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_type = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    test_reset();
    test_fetch();
    test_load_sign();
    test_random_loads();
    test_store();
    test_io_stall();
    test_starve();
    test_flush();
    test_rdy_freeze();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
